// File: rtl/receptor_mdio.sv
// ============================================================================
// Module      : receptor_mdio
// Description : Clause-22 MDIO frame receiver that bridges management read and
//               write frames onto a simple external register-memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module receptor_mdio #(
    parameter logic [4:0] PHY_ADDR = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MDC,
    input  logic        MDIO_OE,
    input  logic        MDIO_OUT,
    output logic        MDIO_IN,
    output logic [4:0]  ADDR,
    output logic [15:0] WR_DATA,
    output logic        MEM_WR,
    output logic        MEM_RD,
    input  logic [15:0] RD_DATA_MEM
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HEADER    = 3'd1,
        S_WR_DATA   = 3'd2,
        S_RD_FETCH  = 3'd3,
        S_RD_DATA   = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_mdc;
    logic [5:0]  r_cnt;
    logic [14:0] r_shift;
    logic [15:0] r_rd_data;
    logic        r_fetch_wait;
    logic        r_mdio_in;
    logic [4:0]  r_addr;
    logic [15:0] r_wr_data;
    logic        r_mem_wr;

    logic        w_rise;
    logic        w_fall;
    logic [5:0]  w_cnt_inc;
    logic [15:0] w_shift;
    logic        w_load_addr;
    logic        w_load_wr;
    logic        w_latch_rd;
    logic        w_drive_bit;
    logic        w_drive_zero;

    assign w_rise    = MDC & ~r_mdc;
    assign w_fall    = ~MDC & r_mdc;
    assign w_cnt_inc = r_cnt + 6'd1;
    // Newest bit lands in bit 0, so after rise n the frame's first n bits sit in [n-1:0]
    assign w_shift   = {r_shift, MDIO_OUT};

    always_comb begin
        w_next       = r_state;
        w_load_addr  = 1'b0;
        w_load_wr    = 1'b0;
        w_latch_rd   = 1'b0;
        w_drive_bit  = 1'b0;
        w_drive_zero = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise && MDIO_OE && !MDIO_OUT)
                    w_next = S_HEADER;
            end
            S_HEADER: begin
                if (w_rise) begin
                    if (!MDIO_OE)
                        w_next = S_WAIT_IDLE;
                    else if (w_cnt_inc == 6'd2 && w_shift[1:0] != 2'b01)
                        w_next = S_WAIT_IDLE;
                    else if (w_cnt_inc == 6'd4 && (w_shift[1:0] == 2'b00 || w_shift[1:0] == 2'b11))
                        w_next = S_WAIT_IDLE;
                    else if (w_cnt_inc == 6'd14) begin
                        if (w_shift[9:5] != PHY_ADDR)
                            w_next = S_WAIT_IDLE;
                        else begin
                            w_load_addr = 1'b1;
                            w_next      = (w_shift[11:10] == 2'b01) ? S_WR_DATA : S_RD_FETCH;
                        end
                    end
                end
            end
            S_WR_DATA: begin
                if (w_rise) begin
                    if (!MDIO_OE)
                        w_next = S_WAIT_IDLE;
                    else if (w_cnt_inc == 6'd32) begin
                        w_load_wr = 1'b1;
                        w_next    = S_IDLE;
                    end
                end
            end
            S_RD_FETCH: begin
                // First clk strobes MEM_RD, second clk captures the returned word
                if (r_fetch_wait) begin
                    w_latch_rd = 1'b1;
                    w_next     = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (w_fall) begin
                    if (r_cnt == 6'd32) begin
                        w_drive_zero = 1'b1;
                        w_next       = S_IDLE;
                    end else if (r_cnt >= 6'd16)
                        w_drive_bit = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (!MDIO_OE)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_mdc        <= 1'b0;
            r_cnt        <= 6'd0;
            r_shift      <= 15'd0;
            r_rd_data    <= 16'd0;
            r_fetch_wait <= 1'b0;
            r_mdio_in    <= 1'b0;
            r_addr       <= 5'd0;
            r_wr_data    <= 16'd0;
            r_mem_wr     <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_mdc        <= MDC;
            r_fetch_wait <= (r_state == S_RD_FETCH) && !r_fetch_wait;
            r_mem_wr     <= w_load_wr;

            if (w_rise)
                r_shift <= w_shift[14:0];

            if (w_next == S_IDLE)
                r_cnt <= 6'd0;
            else if (r_state == S_IDLE)
                r_cnt <= 6'd1;
            else if (w_rise && r_state != S_WAIT_IDLE)
                r_cnt <= w_cnt_inc;

            if (w_load_addr)
                r_addr <= w_shift[4:0];
            if (w_load_wr)
                r_wr_data <= w_shift;

            if (w_latch_rd)
                r_rd_data <= RD_DATA_MEM;
            else if (w_drive_bit)
                r_rd_data <= {r_rd_data[14:0], 1'b0};

            if (w_drive_bit)
                r_mdio_in <= r_rd_data[15];
            else if (w_drive_zero)
                r_mdio_in <= 1'b0;
        end
    end

    assign MDIO_IN = r_mdio_in;
    assign ADDR    = r_addr;
    assign WR_DATA = r_wr_data;
    assign MEM_WR  = r_mem_wr;
    assign MEM_RD  = (r_state == S_RD_FETCH) && !r_fetch_wait;

endmodule

`default_nettype wire

// File: tb/tb_receptor_mdio.sv
// ============================================================================
// Module      : tb_receptor_mdio
// Description : Directed self-checking bench for receptor_mdio.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_receptor_mdio;

    logic        clk;
    logic        rst;
    logic        MDC;
    logic        MDIO_OE;
    logic        MDIO_OUT;
    logic        MDIO_IN;
    logic [4:0]  ADDR;
    logic [15:0] WR_DATA;
    logic        MEM_WR;
    logic        MEM_RD;
    logic [15:0] RD_DATA_MEM;

    logic [15:0] mem_val;
    int          n_checks;
    int          n_errors;
    int          wr_cnt;
    int          rd_cnt;
    int          both_cnt;
    int          hi_cnt;
    logic [4:0]  wr_addr_seen;
    logic [15:0] wr_data_seen;
    logic [4:0]  rd_addr_seen;
    int          w0;
    int          r0;
    int          h0;
    logic [15:0] rd_bits;

    receptor_mdio #(.PHY_ADDR(5'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .MDC        (MDC),
        .MDIO_OE    (MDIO_OE),
        .MDIO_OUT   (MDIO_OUT),
        .MDIO_IN    (MDIO_IN),
        .ADDR       (ADDR),
        .WR_DATA    (WR_DATA),
        .MEM_WR     (MEM_WR),
        .MEM_RD     (MEM_RD),
        .RD_DATA_MEM(RD_DATA_MEM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns the word exactly one clk after the strobe, garbage otherwise
    always @(posedge clk)
        RD_DATA_MEM <= MEM_RD ? mem_val : 16'hDEAD;

    initial begin
        wr_cnt = 0; rd_cnt = 0; both_cnt = 0; hi_cnt = 0;
        wr_addr_seen = 5'd0; wr_data_seen = 16'd0; rd_addr_seen = 5'd0;
    end

    always @(negedge clk) begin
        if (MEM_WR) begin
            wr_cnt       <= wr_cnt + 1;
            wr_addr_seen <= ADDR;
            wr_data_seen <= WR_DATA;
        end
        if (MEM_RD) begin
            rd_cnt       <= rd_cnt + 1;
            rd_addr_seen <= ADDR;
        end
        if (MEM_WR && MEM_RD)
            both_cnt <= both_cnt + 1;
        if (MDIO_IN)
            hi_cnt <= hi_cnt + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mdc_cycle(input logic oe, input logic b, input logic do_rst, output logic s);
        MDIO_OE  = oe;
        MDIO_OUT = b;
        repeat (3) @(negedge clk);
        s   = MDIO_IN;
        MDC = 1'b1;
        if (do_rst) begin
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            check_value("mdio_in_after_rst", 32'(MDIO_IN), 32'd0);
            repeat (2) @(negedge clk);
        end else begin
            repeat (3) @(negedge clk);
        end
        MDC = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] bits, input int oe_until, input int rst_at,
                              output logic [15:0] rdv);
        logic s;
        rdv = 16'd0;
        for (int i = 1; i <= 32; i++) begin
            mdc_cycle(i <= oe_until, bits[32-i], i == rst_at, s);
            if (i >= 17)
                rdv[32-i] = s;
        end
        MDIO_OE  = 1'b0;
        MDIO_OUT = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic snap();
        w0 = wr_cnt;
        r0 = rd_cnt;
        h0 = hi_cnt;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        MDC = 1'b0; MDIO_OE = 1'b0; MDIO_OUT = 1'b0; rst = 1'b0;
        mem_val = 16'h1234;
        repeat (3) @(negedge clk);
        check_value("rst_mdio_in", 32'(MDIO_IN), 32'd0);
        check_value("rst_addr",    32'(ADDR),    32'd0);
        check_value("rst_wr_data", 32'(WR_DATA), 32'd0);
        check_value("rst_mem_wr",  32'(MEM_WR),  32'd0);
        check_value("rst_mem_rd",  32'(MEM_RD),  32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Write A5C3 to register 3
        snap();
        send_frame({2'b01, 2'b01, 5'd0, 5'd3, 2'b10, 16'hA5C3}, 32, 0, rd_bits);
        check_value("wr1_count",    32'(wr_cnt - w0), 32'd1);
        check_value("wr1_rd_count", 32'(rd_cnt - r0), 32'd0);
        check_value("wr1_strobe_addr", 32'(wr_addr_seen), 32'd3);
        check_value("wr1_strobe_data", 32'(wr_data_seen), 32'hA5C3);
        check_value("wr1_addr",     32'(ADDR),    32'd3);
        check_value("wr1_wr_data",  32'(WR_DATA), 32'hA5C3);

        // Read register 7, memory returns 1234
        snap();
        send_frame({2'b01, 2'b10, 5'd0, 5'd7, 2'b00, 16'h0000}, 14, 0, rd_bits);
        check_value("rd1_count",    32'(rd_cnt - r0), 32'd1);
        check_value("rd1_wr_count", 32'(wr_cnt - w0), 32'd0);
        check_value("rd1_strobe_addr", 32'(rd_addr_seen), 32'd7);
        check_value("rd1_bits",     32'(rd_bits), 32'h1234);
        check_value("rd1_mdio_idle", 32'(MDIO_IN), 32'd0);
        check_value("rd1_wr_data_hold", 32'(WR_DATA), 32'hA5C3);

        // Foreign PHY address: frame must be ignored
        snap();
        send_frame({2'b01, 2'b01, 5'd1, 5'd3, 2'b10, 16'hFFFF}, 32, 0, rd_bits);
        check_value("phy_wr_count", 32'(wr_cnt - w0), 32'd0);
        check_value("phy_rd_count", 32'(rd_cnt - r0), 32'd0);
        check_value("phy_mdio_hi",  32'(hi_cnt - h0), 32'd0);
        check_value("phy_addr_hold", 32'(ADDR), 32'd7);

        // Bad start code, then illegal opcode, then a good write
        snap();
        send_frame({2'b00, 2'b01, 5'd0, 5'd3, 2'b10, 16'h1111}, 32, 0, rd_bits);
        check_value("st00_strobes", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);
        snap();
        send_frame({2'b01, 2'b11, 5'd0, 5'd3, 2'b10, 16'h2222}, 32, 0, rd_bits);
        check_value("op11_strobes", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);
        snap();
        send_frame({2'b01, 2'b01, 5'd0, 5'd9, 2'b10, 16'h5A5A}, 32, 0, rd_bits);
        check_value("wr2_count",   32'(wr_cnt - w0), 32'd1);
        check_value("wr2_addr",    32'(ADDR),    32'd9);
        check_value("wr2_wr_data", 32'(WR_DATA), 32'h5A5A);

        // Write aborted at rise 24, then a read
        snap();
        send_frame({2'b01, 2'b01, 5'd0, 5'd2, 2'b10, 16'hBEEF}, 23, 0, rd_bits);
        check_value("abort_wr_count", 32'(wr_cnt - w0), 32'd0);
        check_value("abort_wr_data",  32'(WR_DATA), 32'h5A5A);
        mem_val = 16'hC3A5;
        snap();
        send_frame({2'b01, 2'b10, 5'd0, 5'd4, 2'b00, 16'h0000}, 14, 0, rd_bits);
        check_value("rd2_count", 32'(rd_cnt - r0), 32'd1);
        check_value("rd2_strobe_addr", 32'(rd_addr_seen), 32'd4);
        check_value("rd2_bits",  32'(rd_bits), 32'hC3A5);

        // Reset at rise 20 of a read, then write to register 5
        mem_val = 16'h1234;
        snap();
        send_frame({2'b01, 2'b10, 5'd0, 5'd7, 2'b00, 16'h0000}, 14, 20, rd_bits);
        check_value("rstrd_rd_count", 32'(rd_cnt - r0), 32'd1);
        check_value("rstrd_wr_count", 32'(wr_cnt - w0), 32'd0);
        check_value("rstrd_mdio_in",  32'(MDIO_IN), 32'd0);
        snap();
        send_frame({2'b01, 2'b01, 5'd0, 5'd5, 2'b10, 16'h0F0F}, 32, 0, rd_bits);
        check_value("wr3_count",   32'(wr_cnt - w0), 32'd1);
        check_value("wr3_strobe_addr", 32'(wr_addr_seen), 32'd5);
        check_value("wr3_addr",    32'(ADDR),    32'd5);
        check_value("wr3_wr_data", 32'(WR_DATA), 32'h0F0F);

        check_value("never_both_strobes", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/receptor_mdio.md
RECEPTOR_MDIO -- requirements
Module: receptor_mdio

Interface
REQ-001 The block SHALL have parameter PHY_ADDR, default 5'd0, meaning the PHY address this receiver answers to.
REQ-002 The block SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning synchronous active-low reset.
REQ-004 The block SHALL have port MDC, input, 1, meaning the management clock from the MDIO controller, sampled as data (high and low phases each >= 2 clk cycles).
REQ-005 The block SHALL have port MDIO_OE, input, 1, meaning the controller output-enable.
REQ-006 The block SHALL have port MDIO_OUT, input, 1, meaning the serial frame bit from the controller.
REQ-007 The block SHALL have port MDIO_IN, output, 1, meaning the serial read-data bit returned to the controller.
REQ-008 The block SHALL have port ADDR, output, 5, meaning the register address (REGAD) toward external register memory.
REQ-009 The block SHALL have port WR_DATA, output, 16, meaning the write data toward memory.
REQ-010 The block SHALL have port MEM_WR, output, 1, meaning a one-clk write strobe.
REQ-011 The block SHALL have port MEM_RD, output, 1, meaning a one-clk read strobe.
REQ-012 The block SHALL have port RD_DATA_MEM, input, 16, meaning memory read data, valid exactly 1 clk after MEM_RD.

Function
REQ-013 The block SHALL detect MDC edges by registering MDC and comparing it with the current value; "rise" and "fall" below mean these detected edges.
REQ-014 The block SHALL sample MDIO_OUT only on a rise; rises within a frame are numbered 1..32 by a 6-bit counter.
REQ-015 The frame SHALL be decoded MSB first: rises 1-2 ST (must be 01), 3-4 OP (01 write, 10 read), 5-9 PHYAD, 10-14 REGAD, 15-16 TA, 17-32 DATA.
REQ-016 The FSM SHALL have states IDLE, HEADER, WR_DATA, RD_FETCH, RD_DATA, and WAIT_IDLE.
REQ-017 IDLE SHALL go to HEADER on a rise with MDIO_OE=1 and MDIO_OUT=0 (rise 1); any other rise SHALL be ignored.
REQ-018 In HEADER, ST!=01, OP in {00,11}, or MDIO_OE=0 on any rise SHALL go to WAIT_IDLE; WAIT_IDLE SHALL return to IDLE on the first clk with MDIO_OE=0.
REQ-019 At rise 14, PHYAD!=PHY_ADDR SHALL go to WAIT_IDLE, with no memory access and MDIO_IN held at 0.
REQ-020 A write with a matching address SHALL go to WR_DATA and shift bits 17-32 into WR_DATA; TA bits SHALL be ignored.
REQ-021 In WR_DATA, MDIO_OE=0 on any rise SHALL abort to WAIT_IDLE with no MEM_WR.
REQ-022 The clk after rise 32 of a write SHALL carry MEM_WR=1 for exactly 1 clk with ADDR=REGAD and WR_DATA stable; the FSM SHALL then return to IDLE.
REQ-023 A read with a matching address SHALL assert MEM_RD=1 for 1 clk (ADDR=REGAD) on the clk after rise 14, latch RD_DATA_MEM on the following clk (RD_FETCH), then enter RD_DATA.
REQ-024 In RD_DATA, MDIO_OE SHALL be ignored (the controller releases the line).
REQ-025 MDIO_IN SHALL be 0 through TA and SHALL change only on a fall.
REQ-026 On the fall after rise 16+k (k=0..15), MDIO_IN SHALL take latched bit 15-k, so the controller samples it at rise 17+k.
REQ-027 On the fall after rise 32, MDIO_IN SHALL return to 0 and the FSM to IDLE.
REQ-028 MEM_WR and MEM_RD SHALL never be high in the same clk; ADDR and WR_DATA SHALL hold their last values between frames.
REQ-029 A frame SHALL cause at most one memory strobe.

Reset
REQ-030 When rst=0 at a clk edge, the FSM SHALL be IDLE, the counter 0, MDIO_IN=0, ADDR=0, WR_DATA=0, MEM_WR=0, MEM_RD=0, and the MDC edge register 0.
REQ-031 Reset mid-frame SHALL discard the frame with no strobe; the next frame SHALL decode normally.

Verification
REQ-032 The bench SHALL cover: write frame 01_01_00000_00011_10_A5C3, OE high for 32 rises -> one MEM_WR, ADDR=3, WR_DATA=16'hA5C3.
REQ-033 The bench SHALL cover: read frame 01_10_00000_00111, memory returns 16'h1234 -> one MEM_RD with ADDR=7; MDIO_IN sampled at rises 17-32 reads 0001_0010_0011_0100.
REQ-034 The bench SHALL cover: write to PHYAD 00001 with PHY_ADDR=0 -> no strobes, MDIO_IN=0 for the whole frame.
REQ-035 The bench SHALL cover: frame with ST=00 or OP=11 -> WAIT_IDLE, no strobes; the next valid write completes normally.
REQ-036 The bench SHALL cover: OE dropped at rise 24 of a write -> no MEM_WR; the next read returns correct data.
REQ-037 The bench SHALL cover: rst=0 at rise 20 of a read -> MDIO_IN=0 next clk, and a following write to address 5 produces MEM_WR with ADDR=5.
